// File: rtl/regfile_mp_sb.sv
// Multi-port register file with an integrated busy/scoreboard table for the ID stage.
// Reads are combinational with optional same-cycle write forwarding; state updates at posedge.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR*ADDR_W-1:0]   wr_addr,
    input  logic [NWR*DATA_W-1:0]   wr_data,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_rd,
    output logic                    iss_ok,
    input  logic                    flush,
    output logic [NREG-1:0]         busy_vec
);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   wr_hit;
    logic [NREG-1:0]   iss_set;
    logic              iss_valid;
    logic              iss_hazard;

    // An index names a real, writable register: in range and not the hardwired zero.
    function automatic logic idx_valid(input logic [ADDR_W-1:0] a);
        return (32'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        wr_hit = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && idx_valid(wr_addr[j*ADDR_W +: ADDR_W])) begin
                wr_hit[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              pend;

        assign addr = rd_addr[i*ADDR_W +: ADDR_W];

        // Ascending port scan lets the highest-numbered matching writer win the forward.
        always_comb begin
            data = '0;
            pend = 1'b0;
            if (idx_valid(addr)) begin
                data = regs[addr];
                pend = busy[addr];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == addr)) begin
                            data = wr_data[j*DATA_W +: DATA_W];
                            pend = 1'b0;
                        end
                    end
                end
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = data;
        assign rd_busy[i]                  = pend;
    end

    assign iss_valid  = idx_valid(iss_rd);
    assign iss_hazard = iss_valid && busy[iss_rd] && !((BYPASS != 0) && wr_hit[iss_rd]);
    assign iss_ok     = iss_en && !flush && !iss_hazard;
    assign busy_vec   = busy;

    always_comb begin
        iss_set = '0;
        if (iss_ok && iss_valid) begin
            iss_set[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && idx_valid(wr_addr[j*ADDR_W +: ADDR_W])) begin
                    regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // A new producer supersedes a completing one, so set is applied after clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~wr_hit) | iss_set;
        end
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file with a built-in busy/scoreboard table.
- Generalises the single-write, dual-read register file to NRD read ports and NWR write ports, with optional write-to-read bypass.
- Tracks which registers have an in-flight producer. The ID stage uses this to detect RAW/WAW hazards and to gate issue.
- Sits in ID; write ports are driven by WB (and MEM for late-completing loads when NWR>1).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width.
- NREG, 32, number of registers; must be ≤ 2**ADDR_W.
- NRD, 2, number of read ports.
- NWR, 1, number of write ports.
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads and clears busy for hazard checks; 0 = no forwarding.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, and is never busy.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NRD*ADDR_W  read indices; port i uses slice [i*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  read data per port.
- rd_busy  out  NRD  per-port: source register has a pending producer.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*ADDR_W  write indices.
- wr_data  in  NWR*DATA_W  write data.
- iss_en  in  1  ID requests issue of an instruction with a destination.
- iss_rd  in  ADDR_W  destination of the issuing instruction.
- iss_ok  out  1  issue accepted this cycle.
- flush  in  1  pipeline flush; discards all pending producers.
- busy_vec  out  NREG  current scoreboard state (registered view).

Behaviour:
- Reset (async, rst=1):
  - All registers are 0 and all busy bits are 0.
  - Consequently rd_data=0, rd_busy=0, busy_vec=0, and iss_ok=iss_en.
  - Reset asserted mid-operation discards all writes and busy state immediately, without waiting for a clock edge.
- Writes:
  - Take effect at the posedge when wr_en[j]=1.
  - Indices ≥ NREG are ignored.
  - When ZERO_REG=1, writes to index 0 are ignored.
  - If multiple ports write the same index in one cycle, the highest-numbered port wins.
- Reads:
  - Combinational; 0-cycle latency from rd_addr.
  - Index ≥ NREG returns 0.
  - When ZERO_REG=1, index 0 always returns 0.
  - When BYPASS=1 and a write port targets the same valid index in the same cycle, rd_data returns that port's wr_data (highest matching port wins); otherwise it returns the stored value.
- Busy bits (per register, set/clear at posedge, priority highest first):
  1. flush=1: all busy bits are cleared. Writes in the same cycle still commit; issue in the same cycle sets nothing.
  2. Issue set: iss_ok=1 and iss_rd valid (not 0 when ZERO_REG=1, < NREG) sets busy[iss_rd].
  3. Write clear: any wr_en targeting index k clears busy[k].
  - Set wins over clear on the same index in the same cycle, because the new producer supersedes the completing one.
- iss_ok (combinational):
  - iss_ok = iss_en & ~flush & ~hazard.
  - hazard = busy[iss_rd] & ~(BYPASS & a write to iss_rd this cycle). This blocks WAW.
  - iss_rd = 0 with ZERO_REG=1 never has a hazard.
- rd_busy[i] = busy[rd_addr_i] & ~(BYPASS & a write to rd_addr_i this cycle). It is 0 for index 0 when ZERO_REG=1 and for out-of-range indices.
- busy_vec shows the registered state only; it has no bypass term.
- No internal pipelining. Everything is either combinational or has 1-cycle state update latency.

Test Plan:
- Reset then read: rst pulse, rd_addr={5,0} -> rd_data={0,0}, busy_vec=0; rst asserted while iss_en=1, iss_rd=3 -> busy_vec stays 0.
- Write/read with bypass (BYPASS=1): cycle N wr_en=1, wr_addr=7, wr_data=0xDEADBEEF, rd_addr[0]=7 -> rd_data[0]=0xDEADBEEF in cycle N; with BYPASS=0 -> old value in N, 0xDEADBEEF in N+1.
- x0 hardwire: write 0x1234 to 0, then read 0 -> 0; iss_en=1, iss_rd=0 -> iss_ok=1, busy_vec[0] stays 0.
- Scoreboard round trip: issue rd=9 -> busy_vec[9]=1 next cycle; rd_addr=9 -> rd_busy=1; second issue rd=9 -> iss_ok=0; WB writes 9 -> same-cycle iss_ok=1 (BYPASS=1), and busy_vec[9] remains 1 next cycle because set wins.
- Multi-port conflict (NWR=2): both ports write index 4 with 0xA and 0xB -> reg4=0xB; rd_data via bypass=0xB; busy[4] cleared.
- Flush: busy regs {2,6} set, flush=1 with iss_en=1, iss_rd=8 and wr 6=0x55 -> iss_ok=0, busy_vec=0 next cycle, reg6=0x55.
